// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and skid-buffer operation encoding
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int SKID_DEPTH      = 2;
  localparam int SKID_CNT_WIDTH  = 2;

  // {push, pop} pair as seen by the skid buffer in one cycle
  typedef enum logic [1:0] {
    SKID_IDLE = 2'b00,
    SKID_POP  = 2'b01,
    SKID_PUSH = 2'b10,
    SKID_BOTH = 2'b11
  } skid_op_e;

endpackage

// File: rtl/fifo_read_stage_if.sv
// rtl/fifo_read_stage_if.sv - valid/ready word stream toward the downstream stage
interface fifo_read_stage_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/rd_skid_buffer.sv
// rtl/rd_skid_buffer.sv - 2-entry in-order skid buffer with push/pop/flush
module rd_skid_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic                      valid,
  output logic [DATA_WIDTH-1:0]     head,
  output logic [SKID_CNT_WIDTH-1:0] count
);

  logic [DATA_WIDTH-1:0]     entry0;
  logic [DATA_WIDTH-1:0]     entry1;
  logic [SKID_CNT_WIDTH-1:0] count_q;
  skid_op_e                  op;

  assign op = skid_op_e'({push, pop});

  // entry0 is always the head; a pop shifts entry1 forward, flush drops everything
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      entry0  <= '0;
      entry1  <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case (op)
        SKID_PUSH: begin
          if (count_q == '0) entry0 <= push_data;
          else               entry1 <= push_data;
          count_q <= count_q + SKID_CNT_WIDTH'(1);
        end
        SKID_POP: begin
          entry0  <= entry1;
          count_q <= count_q - SKID_CNT_WIDTH'(1);
        end
        SKID_BOTH: begin
          if (count_q == SKID_CNT_WIDTH'(1)) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (count_q != '0);
  assign head  = entry0;
  assign count = count_q;

endmodule

// File: rtl/fifo_read_stage.sv
// rtl/fifo_read_stage.sv - async FIFO read-side drain stage; FIFO_RD_PARITY_EN enables parity check
module fifo_read_stage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fifo_empty,
  input  logic [DATA_WIDTH:0]       fifo_r_data,
  output logic                      fifo_r_en,
  output logic [ADDR_WIDTH-1:0]     fifo_r_adrs,
  input  logic                      flush,
  fifo_read_stage_if.master         out,
  output logic [SKID_CNT_WIDTH-1:0] out_count,
  output logic                      parity_err
);

  logic       pop;
  logic       inflight;
  logic       room;
  logic [2:0] pending;

  assign pop = out.valid & out.ready;

  // Slots committed after this edge: buffered + returning word, minus the one leaving.
  // Counting the pop lets a read issue in the same cycle a stall releases.
  assign pending   = {1'b0, out_count} + {2'b00, inflight} - {2'b00, pop};
  assign room      = (pending < 3'(SKID_DEPTH));
  assign fifo_r_en = !reset & !flush & !fifo_empty & room;

  // Read pointer wraps naturally; the in-flight flag tracks the RAM's one-cycle latency
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_r_adrs <= '0;
      inflight    <= 1'b0;
    end else begin
      if (fifo_r_en) fifo_r_adrs <= fifo_r_adrs + ADDR_WIDTH'(1);
      inflight <= fifo_r_en;
    end
  end

`ifdef FIFO_RD_PARITY_EN
  logic parity_q;

  // Sticky flag on any captured word whose total parity (data + parity bit) is odd
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (inflight && !flush && (^fifo_r_data)) begin
      parity_q <= 1'b1;
    end
  end

  assign parity_err = parity_q;
`else
  logic unused_parity_bit;
  assign unused_parity_bit = fifo_r_data[DATA_WIDTH];
  assign parity_err        = 1'b0;
`endif

  rd_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (inflight),
    .push_data(fifo_r_data[DATA_WIDTH-1:0]),
    .pop      (pop),
    .valid    (out.valid),
    .head     (out.data),
    .count    (out_count)
  );

endmodule

// File: tb/tb_fifo_read_stage.sv
// tb/tb_fifo_read_stage.sv - directed self-checking bench for fifo_read_stage
module tb_fifo_read_stage;
  import fifo_pkg::*;

  localparam int DW = 32;
  localparam int AW = 3;
`ifdef FIFO_RD_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW:0]   fifo_r_data = '0;
  logic          fifo_r_en;
  logic [AW-1:0] fifo_r_adrs;
  logic          flush;
  logic [1:0]    out_count;
  logic          parity_err;

  fifo_read_stage_if #(.DATA_WIDTH(DW)) out_if ();

  fifo_read_stage #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_r_en  (fifo_r_en),
    .fifo_r_adrs(fifo_r_adrs),
    .flush      (flush),
    .out        (out_if),
    .out_count  (out_count),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int            total_pushed = 0;
  int            corrupt_idx  = -1;
  bit            force_empty  = 1'b0;
  int            rd_idx = 0;
  int            cycle  = 0;
  int            exp_idx;
  int            ren_cyc [64];
  int            pop_cyc [64];
  logic [AW-1:0] adrs_log[64];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] saved_adrs;

  assign fifo_empty = force_empty || (rd_idx >= total_pushed);

  // Word idx is 0x100+idx with even parity, except the injected corrupt index
  function automatic logic [DW:0] make_data(input int idx);
    logic [DW-1:0] w;
    w = DW'(32'h100 + idx);
    return {(^w) ^ (idx == corrupt_idx), w};
  endfunction

  // Model FIFO RAM: one-cycle read latency, logs every issued read
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (fifo_r_en && rd_idx < 64) begin
      fifo_r_data      <= make_data(rd_idx);
      ren_cyc[rd_idx]  <= cycle;
      adrs_log[rd_idx] <= fifo_r_adrs;
      rd_idx           <= rd_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Sample the handshake with this cycle's inputs, then advance to the next negedge
  task automatic tick();
    #1;
    if (out_if.valid && out_if.ready) begin
      check("out_data", 64'(out_if.data), 64'(32'h100 + exp_idx));
      if (exp_idx < 64) pop_cyc[exp_idx] = cycle;
      exp_idx++;
    end
    @(negedge clk);
  endtask

  task automatic wait_words(input int target, input int budget);
    for (int i = 0; i < budget && exp_idx < target; i++) tick();
    check("drain_done", 64'(exp_idx), 64'(target));
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    out_if.ready  = 1'b0;
    exp_idx       = 0;
    total_pushed  = 10;
    @(negedge clk);
    tick();

    // reset held with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_ren",   64'(fifo_r_en),    64'(0));
      check("rst_adrs",  64'(fifo_r_adrs),  64'(0));
      check("rst_valid", 64'(out_if.valid), 64'(0));
      check("rst_count", 64'(out_count),    64'(0));
      tick();
    end

    // streaming 10 words across the address wrap
    reset        = 1'b0;
    out_if.ready = 1'b1;
    wait_words(10, 40);
    for (int i = 0; i < 10; i++) begin
      check("wrap_adrs", 64'(adrs_log[i]), 64'(i % 8));
      check("pop_cycle", 64'(pop_cyc[i]),  64'(ren_cyc[0] + 2 + i));
    end
    check("stream_adrs_end", 64'(fifo_r_adrs),  64'(2));
    check("stream_idle",     64'(out_if.valid), 64'(0));

    // backpressure: exactly two reads issue, then stall
    out_if.ready = 1'b0;
    total_pushed = 16;
    repeat (6) tick();
    #1;
    check("bp_count", 64'(out_count), 64'(2));
    check("bp_ren",   64'(fifo_r_en), 64'(0));
    check("bp_reads", 64'(rd_idx),    64'(12));
    out_if.ready = 1'b1;
    #1;
    check("bp_release_ren", 64'(fifo_r_en), 64'(1));
    wait_words(16, 30);

    // FIFO empty for 4 cycles mid-stream
    total_pushed = 24;
    tick();
    tick();
    force_empty = 1'b1;
    saved_adrs  = fifo_r_adrs;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("empty_ren", 64'(fifo_r_en), 64'(0));
      tick();
    end
    check("empty_adrs",  64'(fifo_r_adrs),  64'(saved_adrs));
    check("empty_valid", 64'(out_if.valid), 64'(0));
    force_empty = 1'b0;
    wait_words(24, 30);

    // flush with one word buffered and one in flight
    out_if.ready = 1'b0;
    total_pushed = 32;
    tick();
    tick();
    check("pre_flush_count", 64'(out_count), 64'(1));
    flush = 1'b1;
    #1;
    check("flush_ren", 64'(fifo_r_en), 64'(0));
    saved_adrs = fifo_r_adrs;
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(out_if.valid), 64'(0));
    check("flush_count", 64'(out_count),    64'(0));
    check("flush_adrs",  64'(fifo_r_adrs),  64'(saved_adrs));
    check("flush_reads", 64'(rd_idx),       64'(26));
    exp_idx      = rd_idx;
    out_if.ready = 1'b1;
    wait_words(32, 30);

    // corrupt parity on word 34; word still delivered
    check("parity_clean", 64'(parity_err), 64'(0));
    corrupt_idx  = 34;
    total_pushed = 36;
    wait_words(36, 30);
    check("parity_sticky", 64'(parity_err), 64'(PAR_EN));

    // reset mid-operation clears pointer and sticky flag
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst2_parity", 64'(parity_err),   64'(0));
    check("rst2_adrs",   64'(fifo_r_adrs),  64'(0));
    check("rst2_count",  64'(out_count),    64'(0));
    check("rst2_valid",  64'(out_if.valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
